complex_diff_unit: RTL

- Inverse of the FFT datapath's complex accumulation stage: turns a stream of packed complex running sums into first differences, so that y[n] = x[n] − x[n−1] on each component.
- The first sample of every frame is differenced against zero, mirroring the accumulator clear at frame start.
- Sits ahead of the accumulation stage as its stimulus and inverse-check path.
- Valid/ready handshakes on both sides, one registered output stage.

---
 rtl/fft_pkg.sv | 39 +++
 rtl/cplx_sub_ovf.sv | 21 ++
 rtl/complex_diff_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT datapath's complex stages.
package fft_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_FRAME_LEN = 8;

  // Packed complex sample, real part in the upper half of the word.
  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] re;
    logic signed [DEF_DATA_W-1:0] im;
  } cplx_t;

  // Wrapped difference plus per-component {real, imag} overflow.
  typedef struct packed {
    cplx_t      diff;
    logic [1:0] ovf;
  } cplx_diff_t;

  typedef enum logic {
    S_FIRST,
    S_RUN
  } state_t;

  // Component-wise a - b, wrapped to DEF_DATA_W, with a flag per component
  // when the true difference does not fit the signed range.
  function automatic cplx_diff_t cplx_sub(input cplx_t a, input cplx_t b);
    logic [DEF_DATA_W:0] fullRe;
    logic [DEF_DATA_W:0] fullIm;
    cplx_diff_t          res;
    fullRe      = {a.re[DEF_DATA_W-1], a.re} - {b.re[DEF_DATA_W-1], b.re};
    fullIm      = {a.im[DEF_DATA_W-1], a.im} - {b.im[DEF_DATA_W-1], b.im};
    res.diff.re = fullRe[DEF_DATA_W-1:0];
    res.diff.im = fullIm[DEF_DATA_W-1:0];
    res.ovf[1]  = fullRe[DEF_DATA_W] ^ fullRe[DEF_DATA_W-1];
    res.ovf[0]  = fullIm[DEF_DATA_W] ^ fullIm[DEF_DATA_W-1];
    return res;
  endfunction

endpackage

// File: rtl/cplx_sub_ovf.sv
// One component of the complex subtractor: wrapped difference plus a flag
// when the true (W+1)-bit result falls outside the W-bit signed range.
module cplx_sub_ovf #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_ovf
);

  logic [W:0] w_full;

  // Sign-extend both operands so the top two bits disagree exactly on overflow.
  always_comb begin
    w_full = {i_a[W-1], i_a} - {i_b[W-1], i_b};
    o_diff = w_full[W-1:0];
    o_ovf  = w_full[W] ^ w_full[W-1];
  end

endmodule

// File: rtl/complex_diff_unit.sv
// First-difference stage for packed complex running sums: y[n] = x[n] - x[n-1]
// per component, with the first sample of each frame referenced to zero.
module complex_diff_unit
  import fft_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ce,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [2*DATA_W-1:0] i_in_data,
  input  logic                i_in_sof,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [2*DATA_W-1:0] o_out_data,
  output logic                o_out_sof,
  output logic                o_out_eof,
  output logic [1:0]          o_out_ovf
);

  localparam int               CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t              r_state;
  state_t              w_stateNext;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_prevRe;
  logic [DATA_W-1:0]   r_prevIm;
  logic                r_outValid;
  logic [2*DATA_W-1:0] r_outData;
  logic                r_outSof;
  logic                r_outEof;
  logic [1:0]          r_outOvf;

  logic                w_inXfer;
  logic                w_outXfer;
  logic                w_isFirst;
  logic                w_isLast;
  logic [CNT_W-1:0]    w_effCnt;
  logic [CNT_W-1:0]    w_cntNext;
  logic [DATA_W-1:0]   w_refRe;
  logic [DATA_W-1:0]   w_refIm;
  logic [DATA_W-1:0]   w_diffRe;
  logic [DATA_W-1:0]   w_diffIm;
  logic                w_ovfRe;
  logic                w_ovfIm;

  // Without a skid buffer, a new sample is taken only when the output slot
  // is empty or being drained this cycle.
  assign o_in_ready = i_ce && (!r_outValid || i_out_ready);
  assign w_inXfer   = i_in_valid && o_in_ready;
  assign w_outXfer  = r_outValid && i_out_ready && i_ce;

  // Frame position and FSM next state; in_sof overrides the state so a
  // resync sample always restarts the count against a zero reference.
  always_comb begin
    w_stateNext = r_state;
    w_isFirst   = (r_state == S_FIRST) || i_in_sof;
    w_effCnt    = w_isFirst ? '0 : r_cnt;
    w_isLast    = (w_effCnt == LAST_CNT);
    w_cntNext   = w_isLast ? '0 : w_effCnt + 1'b1;
    w_refRe     = w_isFirst ? '0 : r_prevRe;
    w_refIm     = w_isFirst ? '0 : r_prevIm;
    if (w_inXfer) begin
      w_stateNext = w_isLast ? S_FIRST : S_RUN;
    end
  end

  cplx_sub_ovf #(.W(DATA_W)) u_subRe (
    .i_a    (i_in_data[2*DATA_W-1:DATA_W]),
    .i_b    (w_refRe),
    .o_diff (w_diffRe),
    .o_ovf  (w_ovfRe)
  );

  cplx_sub_ovf #(.W(DATA_W)) u_subIm (
    .i_a    (i_in_data[DATA_W-1:0]),
    .i_b    (w_refIm),
    .o_diff (w_diffIm),
    .o_ovf  (w_ovfIm)
  );

  // FSM state register; only moves on an accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FIRST;
    end else if (i_ce) begin
      r_state <= w_stateNext;
    end
  end

  // Sample counter and previous-sample reference, updated on input transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_prevRe <= '0;
      r_prevIm <= '0;
    end else if (w_inXfer) begin
      r_cnt    <= w_cntNext;
      r_prevRe <= i_in_data[2*DATA_W-1:DATA_W];
      r_prevIm <= i_in_data[DATA_W-1:0];
    end
  end

  // Output register: loads on input transfer, empties on a bare output
  // transfer, and otherwise holds so stalled data stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outSof   <= 1'b0;
      r_outEof   <= 1'b0;
      r_outOvf   <= 2'b00;
    end else if (w_inXfer) begin
      r_outValid <= 1'b1;
      r_outData  <= {w_diffRe, w_diffIm};
      r_outSof   <= w_isFirst;
      r_outEof   <= w_isLast;
      r_outOvf   <= {w_ovfRe, w_ovfIm};
    end else if (w_outXfer) begin
      r_outValid <= 1'b0;
    end
  end

  assign o_out_valid = r_outValid;
  assign o_out_data  = r_outData;
  assign o_out_sof   = r_outSof;
  assign o_out_eof   = r_outEof;
  assign o_out_ovf   = r_outOvf;

endmodule
